// File: rtl/conv_stat_pkg.sv
// Shared sizes, types and the pixel ROM function for the 3x3 convolution wrapper.
package conv_stat_pkg;
    localparam int IMG_ROWS = 10;
    localparam int IMG_COLS = 12;
    localparam int K        = 3;
    localparam int OUT_ROWS = 8;
    localparam int OUT_COLS = 10;
    localparam int DATA_W   = 32;
    localparam int NPIX     = IMG_ROWS * IMG_COLS;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_IMAGE, ST_CONV, ST_DONE} state_t;

    typedef logic [DATA_W-1:0]                    data_t;
    typedef data_t [0:K-1][0:K-1]                 kernel_t;
    typedef data_t [0:OUT_ROWS-1][0:OUT_COLS-1]   result_t;
    typedef data_t [0:NPIX-1]                     img_t;

    // pixel(r,c) = r*12 + c + 1, i.e. address + 1
    function automatic data_t rom_pixel(input logic [6:0] addr);
        return data_t'(addr) + data_t'(1);
    endfunction
endpackage

// File: rtl/conv_core.sv
// One 3x3 correlation output per cycle, row-major, 9 parallel multipliers + adder tree.
module conv_core
    import conv_stat_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  img_t    i_img,
    input  kernel_t i_kernel,
    input  logic    i_start,
    output result_t o_result,
    output logic    o_done
);
    logic                r_busy;
    logic [2:0]          r_row;
    logic [3:0]          r_col;
    logic [6:0]          w_base;
    data_t [0:K*K-1]     w_prod;
    data_t [0:3]         w_s1;
    data_t [0:1]         w_s2;
    data_t               w_sum;

    assign w_base = 7'(r_row) * 7'(IMG_COLS) + 7'(r_col);

    for (genvar a = 0; a < K; a++) begin : g_row
        for (genvar b = 0; b < K; b++) begin : g_col
            assign w_prod[a*K+b] = i_kernel[a][b] * i_img[w_base + 7'(a*IMG_COLS + b)];
        end
    end

    assign w_s1[0] = w_prod[0] + w_prod[1];
    assign w_s1[1] = w_prod[2] + w_prod[3];
    assign w_s1[2] = w_prod[4] + w_prod[5];
    assign w_s1[3] = w_prod[6] + w_prod[7];
    assign w_s2[0] = w_s1[0] + w_s1[1];
    assign w_s2[1] = w_s1[2] + w_s1[3];
    assign w_sum   = w_s2[0] + w_s2[1] + w_prod[8];

    // Combinational so the wrapper leaves ST_CONV on the cycle the last output is written.
    assign o_done = r_busy && (r_row == 3'(OUT_ROWS-1)) && (r_col == 4'(OUT_COLS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            o_result <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_row  <= '0;
            r_col  <= '0;
        end else if (r_busy) begin
            o_result[r_row][r_col] <= w_sum;
            if (r_col == 4'(OUT_COLS-1)) begin
                r_col <= '0;
                if (r_row == 3'(OUT_ROWS-1)) r_busy <= 1'b0;
                else                         r_row  <= r_row + 3'd1;
            end else begin
                r_col <= r_col + 4'd1;
            end
        end
    end
endmodule

// File: rtl/conv_stat_wrapper.sv
// Run controller: loads the fixed image from ROM, runs conv_core, reports run length.
module conv_stat_wrapper
    import conv_stat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  kernel_t           kernel_in,
    output result_t           result_out,
    output logic              done,
    output logic [DATA_W-1:0] cycle_count
);
    state_t            r_state;
    kernel_t           r_kernel;
    img_t              r_img;
    logic [6:0]        r_rd_cnt;
    data_t             r_rom_q;
    logic              r_counting;
    logic [DATA_W-1:0] r_cyc_cnt;
    logic              r_conv_start;
    logic              w_conv_done;

    // Inferred ROM, one cycle read latency.
    always_ff @(posedge clk) r_rom_q <= rom_pixel(r_rd_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_kernel     <= '0;
            r_img        <= '0;
            r_rd_cnt     <= '0;
            r_counting   <= 1'b0;
            r_cyc_cnt    <= '0;
            r_conv_start <= 1'b0;
            done         <= 1'b0;
            cycle_count  <= '0;
        end else begin
            r_conv_start <= 1'b0;
            done         <= 1'b0;
            if (r_counting) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_kernel   <= kernel_in;
                    r_rd_cnt   <= '0;
                    r_cyc_cnt  <= '0;
                    r_counting <= 1'b1;
                    r_state    <= ST_LOAD_IMAGE;
                end
                ST_LOAD_IMAGE: begin
                    // data for address n arrives while the counter reads n+1
                    if (r_rd_cnt != 7'd0) r_img[r_rd_cnt - 7'd1] <= r_rom_q;
                    if (r_rd_cnt == 7'(NPIX)) begin
                        r_conv_start <= 1'b1;
                        r_state      <= ST_CONV;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 7'd1;
                    end
                end
                ST_CONV: if (w_conv_done) begin
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_counting  <= 1'b0;
                    cycle_count <= r_cyc_cnt;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    conv_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_img    (r_img),
        .i_kernel (r_kernel),
        .i_start  (r_conv_start),
        .o_result (result_out),
        .o_done   (w_conv_done)
    );
endmodule

// File: tb/tb_conv_stat_wrapper.sv
// Directed bench for conv_stat_wrapper with hand-computed expected values.
module tb_conv_stat_wrapper;
    import conv_stat_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    kernel_t     kernel_in = '0;
    result_t     result_out;
    logic        done;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_stat_wrapper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .kernel_in   (kernel_in),
        .result_out  (result_out),
        .done        (done),
        .cycle_count (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    // 0: k=1..9 row-major, 1: k=9-3a-b, 2: zero, 3: all ones
    function automatic kernel_t mk_k(input int mode);
        kernel_t k;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                case (mode)
                    0:       k[a][b] = 32'(3*a + b + 1);
                    1:       k[a][b] = 32'(9 - 3*a - b);
                    2:       k[a][b] = 32'd0;
                    default: k[a][b] = 32'hFFFF_FFFF;
                endcase
        return k;
    endfunction

    // entries differing from base + si*i + sj*j
    function automatic int n_off(input result_t r, input int base, input int si, input int sj);
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 10; j++)
                if (r[i][j] !== 32'(base + si*i + sj*j)) n++;
        return n;
    endfunction

    task automatic start_run(input kernel_t k);
        @(negedge clk);
        kernel_in = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = 0;
        while (!done && lat < max) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, cnt;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cyc", cycle_count, 32'd0);
        chk("rst_res", 32'(n_off(result_out, 0, 0, 0)), 32'd0);
        rst_n = 1'b1;

        // run A: kernel 1..9
        start_run(mk_k(0));
        wait_done(400, lat);
        chk("A_lat", 32'(lat), 32'd202);
        chk("A_00", result_out[0][0], 32'd852);
        chk("A_01", result_out[0][1], 32'd897);
        chk("A_10", result_out[1][0], 32'd1392);
        chk("A_79", result_out[7][9], 32'd5037);
        chk("A_all", 32'(n_off(result_out, 852, 540, 45)), 32'd0);
        count_done(5, cnt);
        chk("A_single", 32'(cnt), 32'd0);
        chk("A_cyc", cycle_count, 32'd202);

        // run B: kernel 9-3a-b
        start_run(mk_k(1));
        wait_done(400, lat);
        chk("B_lat", 32'(lat), 32'd202);
        chk("B_00", result_out[0][0], 32'd408);
        chk("B_79", result_out[7][9], 32'd4593);
        chk("B_all", 32'(n_off(result_out, 408, 540, 45)), 32'd0);

        // run C back-to-back; kernel and start change mid ST_CONV
        start_run(mk_k(0));
        chk("B_cyc_hold", cycle_count, 32'd202);
        repeat (140) @(negedge clk);
        kernel_in = mk_k(1);
        start = 1'b1;
        wait_done(200, lat);
        start = 1'b0;
        chk("C_lat", 32'(lat), 32'd62);
        chk("C_all", 32'(n_off(result_out, 852, 540, 45)), 32'd0);
        count_done(250, cnt);
        chk("C_single", 32'(cnt), 32'd0);
        chk("C_cyc", cycle_count, 32'd202);

        // run D: reset during image load
        start_run(mk_k(1));
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("D_rst_done", 32'(done), 32'd0);
        chk("D_rst_cyc", cycle_count, 32'd0);
        chk("D_rst_res", 32'(n_off(result_out, 0, 0, 0)), 32'd0);
        rst_n = 1'b1;
        count_done(250, cnt);
        chk("D_nodone", 32'(cnt), 32'd0);
        start_run(mk_k(0));
        wait_done(400, lat);
        chk("D_lat", 32'(lat), 32'd202);
        chk("D_00", result_out[0][0], 32'd852);
        chk("D_79", result_out[7][9], 32'd5037);
        count_done(3, cnt);
        chk("D_cyc", cycle_count, 32'd202);

        // run E: zero kernel
        start_run(mk_k(2));
        wait_done(400, lat);
        chk("E_lat", 32'(lat), 32'd202);
        chk("E_all", 32'(n_off(result_out, 0, 0, 0)), 32'd0);
        count_done(3, cnt);
        chk("E_cyc", cycle_count, 32'd202);

        // run F: all-ones kernel, result = -(window sum) mod 2^32
        // [0][0] window 1+2+3+13+14+15+25+26+27=126, [7][9] window sum 963
        start_run(mk_k(3));
        wait_done(400, lat);
        chk("F_lat", 32'(lat), 32'd202);
        chk("F_00", result_out[0][0], 32'hFFFF_FF82);
        chk("F_79", result_out[7][9], 32'hFFFF_FC3D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
